// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer
// Paces 12-bit codes from a valid/ready stream into the r2r_dac_buffered macro.
// Samples land in a small FIFO. A programmable divider produces sample ticks,
// and each tick pops one code into the registered DAC data bus. A tick that
// finds the FIFO empty keeps the last code and latches a sticky underflow flag.

module dac_sample_sequencer #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         period,
  input  logic                     invert,
  input  logic [11:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  input  logic                     clr_underflow,
  output logic [11:0]              dac_d,
  output logic                     sample_strobe
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          LW       = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [11:0] MID_CODE = 12'h800;

  logic [DIV_W-1:0] cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [11:0]      mem [DEPTH];

  logic tick;
  logic push;
  logic pop;
  logic empty_tick;

  // Tick and FIFO handshake decode; ready depends on registered occupancy only.
  always_comb begin
    tick       = enable && (cnt == period);
    s_ready    = (level != FULL_LVL);
    push       = s_valid && s_ready;
    pop        = tick && (level != '0);
    empty_tick = tick && (level == '0);
  end

  // Sample-period divider: counts up to period, wraps through all-ones if
  // period is lowered beneath the running count, held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers wrap modulo DEPTH; occupancy is tracked by its own counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // DAC code register; invert is applied at update time because the macro
  // output falls with rising code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_d         <= MID_CODE;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= pop;
      if (pop) begin
        dac_d <= mem[rd_ptr] ^ {12{invert}};
      end
    end
  end

  // Sticky underflow flag; a new empty tick outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (empty_tick) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Self-checking bench for dac_sample_sequencer: a reference model and a
// sample scoreboard advance one clock at a time alongside the design.

module tb_dac_sample_sequencer;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] period;
  logic        invert;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  level;
  logic        underflow;
  logic        clr_underflow;
  logic [11:0] dac_d;
  logic        sample_strobe;

  dac_sample_sequencer #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .period        (period),
    .invert        (invert),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .level         (level),
    .underflow     (underflow),
    .clr_underflow (clr_underflow),
    .dac_d         (dac_d),
    .sample_strobe (sample_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;

  logic [11:0] m_q[$];
  logic [15:0] m_cnt;
  logic [11:0] m_dac;
  logic        m_uf;
  logic        m_strobe;
  logic        last_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt    = '0;
    m_dac    = 12'h800;
    m_uf     = 1'b0;
    m_strobe = 1'b0;
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic cyc();
    logic        en, tk, pu, po, clr;
    logic [11:0] d, pv;
    en  = enable;
    clr = clr_underflow;
    d   = s_data;
    tk  = en && (m_cnt == period);
    pu  = s_valid && (m_q.size() != DEPTH);
    po  = tk && (m_q.size() != 0);
    pv  = po ? (m_q[0] ^ {12{invert}}) : m_dac;
    @(posedge clk);
    #1;
    cyc_no++;
    if (!en || tk) m_cnt = '0;
    else m_cnt = m_cnt + 16'd1;
    if (tk && (m_q.size() == 0)) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    if (po) begin
      void'(m_q.pop_front());
      m_dac = pv;
    end
    if (pu) m_q.push_back(d);
    m_strobe  = po;
    last_push = pu;
    chk("strobe", 32'(sample_strobe), 32'(m_strobe));
    chk("dac_d", 32'(dac_d), 32'(m_dac));
    chk("level", 32'(level), 32'(m_q.size()));
    chk("s_ready", 32'(s_ready), 32'(m_q.size() != DEPTH));
    chk("underflow", 32'(underflow), 32'(m_uf));
  endtask

  initial begin
    int st[$];
    rst_n = 1'b0; enable = 1'b0; period = '0; invert = 1'b0;
    s_data = '0; s_valid = 1'b0; clr_underflow = 1'b0; last_push = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac", 32'(dac_d), 32'h800);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    rst_n = 1'b1;

    // idle with enable low
    repeat (100) cyc();

    // paced playback at period 3
    period = 16'd3;
    s_valid = 1'b1;
    s_data = 12'h000; cyc();
    s_data = 12'h7FF; cyc();
    s_data = 12'hFFF; cyc();
    s_valid = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (sample_strobe) st.push_back(cyc_no);
    end
    chk("paced_strobes", 32'(st.size()), 32'd3);
    if (st.size() == 3) begin
      chk("paced_gap1", 32'(st[1] - st[0]), 32'd4);
      chk("paced_gap2", 32'(st[2] - st[1]), 32'd4);
    end
    chk("paced_uf", 32'(underflow), 32'd1);
    chk("paced_hold", 32'(dac_d), 32'hFFF);
    enable = 1'b0; clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;

    // full and back-pressure
    period = 16'd0;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 12'h100 + 12'(i);
      cyc();
    end
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_level", 32'(level), 32'd8);
    s_data = 12'h1FF;
    repeat (2) cyc();
    enable = 1'b1; cyc();
    enable = 1'b0; cyc();
    s_valid = 1'b0;
    chk("ninth_level", 32'(level), 32'd8);
    enable = 1'b1;
    repeat (12) cyc();
    enable = 1'b0; clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;

    // simultaneous push/pop at level 4
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 12'h200 + 12'(i);
      cyc();
    end
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 12'h300 + 12'(i);
      cyc();
      chk("stream_level", 32'(level), 32'd4);
    end
    s_valid = 1'b0;
    repeat (6) cyc();
    enable = 1'b0; clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;

    // invert
    invert = 1'b1;
    s_valid = 1'b1; s_data = 12'h123; cyc();
    s_valid = 1'b0;
    enable = 1'b1; cyc();
    enable = 1'b0;
    chk("invert_code", 32'(dac_d), 32'hEDC);
    invert = 1'b0;

    // 3 x DEPTH samples across pointer wrap, period 1
    period = 16'd1;
    enable = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      s_data = 12'(i * 97 + 5);
      s_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        cyc();
        if (last_push) break;
      end
      chk("wrap_accept", 32'(last_push), 32'd1);
    end
    s_valid = 1'b0;
    repeat (24) cyc();
    chk("wrap_drained", 32'(level), 32'd0);
    enable = 1'b0; clr_underflow = 1'b1; cyc(); clr_underflow = 1'b0;

    // underflow set beats clear
    period = 16'd0;
    enable = 1'b1; cyc();
    chk("uf_set", 32'(underflow), 32'd1);
    clr_underflow = 1'b1; cyc();
    chk("uf_set_wins", 32'(underflow), 32'd1);
    enable = 1'b0; cyc();
    chk("uf_cleared", 32'(underflow), 32'd0);
    clr_underflow = 1'b0;

    // asynchronous reset mid-stream with level 5
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 12'h400 + 12'(i);
      cyc();
    end
    s_valid = 1'b0;
    enable = 1'b1; cyc();
    enable = 1'b0;
    s_valid = 1'b1; s_data = 12'h4AA; cyc();
    s_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_dac", 32'(dac_d), 32'h800);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_strobe", 32'(sample_strobe), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
